tty_receiver: RTL and testbench
===============================

Name: tty_receiver

Overview:
- Teletype keyboard/reader receiver: the receive-side counterpart of the M707 transmitter, functionally equivalent to the M706.
- Deserialises an asynchronous 1-start / 8-data / stop-bit current-loop line (LSB first, idle = mark = 1) into an 8-bit buffer and raises the keyboard flag.
- Serves the PDP-8/I IOT pulses (skip on flag, clear flag/AC, read buffer) on the positive I/O bus.
- Sits beside the transmitter in the TTY interface and uses the same 8x-baud sample tick source.

Parameters:
- OVERSAMPLE, 8, sample_tick pulses per bit time (power of two, 4..16)
- DEV_CODE, 6'o03, device code matched against mb_dev

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- io_clear  input  1  synchronous IO clear (initialize); same effect as rst, applied on the clk edge
- sample_tick  input  1  one-clk enable at OVERSAMPLE x baud rate
- serial_in  input  1  line from teletype; asynchronous to clk
- mb_dev  input  6  MB[3:8] device code during IOT
- iot  input  1  IOT instruction in progress
- iop1  input  1  one-clk IOP1 pulse
- iop2  input  1  one-clk IOP2 pulse
- iop4  input  1  one-clk IOP4 pulse
- ac_out  output  8  receive buffer gated onto AC[4:11] bus; 0 when not gated
- ac_clear  output  1  request to clear AC
- skip  output  1  skip request
- flag  output  1  keyboard flag; also the interrupt request
- active  output  1  a character is being received
- framing_err  output  1  sticky status: last character had a low stop bit

Behaviour:
- Reset (rst or io_clear):
  - state = IDLE, counters = 0, buffer = 8'h00
  - flag = 0, framing_err = 0
  - all outputs 0
  - synchroniser preset to 1
  - Reset mid-frame abandons the character; no flag is set.
- serial_in passes through a 2-flop synchroniser ("rx") before any use. Line timing below is in sample_ticks, counted from when rx changes.
- State machine: all advances happen only on clk edges where sample_tick = 1; the tick counter counts ticks.
  - IDLE: rx = 0 seen on a tick -> START, tick counter = 0.
  - START: after OVERSAMPLE/2 ticks, sample rx.
    - rx = 0 -> DATA, bit index = 0, counter restarts.
    - rx = 1 -> IDLE (glitch rejected; no flag).
  - DATA: every OVERSAMPLE ticks, sample rx into shift[bit index], LSB first. After bit index 7 -> STOP.
  - STOP: after OVERSAMPLE ticks, sample rx.
    - rx = 1: buffer <= shift, flag <= 1, framing_err <= 0 -> IDLE.
    - rx = 0: buffer <= shift, flag <= 1, framing_err <= 1 -> BREAK.
  - BREAK: wait for rx = 1 on a tick -> IDLE. A held-low line therefore yields exactly one character (8'h00).
- active = 1 in START, DATA and STOP; 0 in IDLE and BREAK.
- Overrun: completion while flag = 1 overwrites buffer; flag stays 1.
- IOT decode: sel = iot & (mb_dev == DEV_CODE). Outputs are combinational and valid the same cycle as the pulse.
  - KSF (IOP1): skip = sel & iop1 & flag.
  - KCC (IOP2): ac_clear = sel & iop2; flag cleared on that edge.
  - KRS (IOP4): ac_out = buffer while sel & iop4; the CPU ORs it into AC.
  - KRB: IOP2 then IOP4 in consecutive pulses; clear, then read. The buffer is unaffected by the flag clear.
- Simultaneous flag set (STOP completion) and flag clear (sel & iop2) on the same edge: set wins; flag = 1 and buffer holds the new character.
- With sample_tick held at 0 the state machine freezes; IOT decode still operates.

Test Plan:
- After reset, send 0x41 at OVERSAMPLE=8:
  - expect active = 1 within 1 tick of the start edge.
  - After 1.5+8 bit times, flag = 1, active = 0, framing_err = 0.
  - KRS gives ac_out = 8'h41.
- Glitch: rx low for 3 ticks, then high -> state back to IDLE; flag = 0; active pulses, then drops 4 ticks after the edge.
- Framing: send 0x00 with a low stop bit, line held low 40 more ticks, then high:
  - flag = 1 once; framing_err = 1; buffer = 8'h00.
  - Then send 0x7F: framing_err = 0, ac_out = 8'h7F.
- IOT sequence on flag set with buffer 0xC5:
  - KSF (sel, iop1) -> skip = 1.
  - KCC (sel, iop2) -> ac_clear = 1, flag = 0 next cycle.
  - KSF -> skip = 0.
  - KRS -> ac_out = 8'hC5.
  - Wrong mb_dev (6'o04) -> skip, ac_clear and ac_out all 0.
- Collision: assert sel & iop2 on the exact edge STOP completes 0x33 -> flag = 1 afterwards, buffer = 8'h33.
- rst asserted mid-DATA (bit 4) -> immediate: active = 0, flag = 0, buffer = 0. A following clean 0x55 frame is received correctly.

Source files
------------

// File: rtl/tty_receiver.sv
`default_nettype none
// ============================================================================
// tty_receiver : PDP-8/I teletype keyboard receiver (M706 equivalent),
//                serial 8N1 deserialiser with KSF/KCC/KRS IOT decode
// Revision     : 1.0
// ============================================================================
module tty_receiver #(
    parameter int         OVERSAMPLE = 8,
    parameter logic [5:0] DEV_CODE   = 6'o03
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       io_clear,
    input  logic       sample_tick,
    input  logic       serial_in,
    input  logic [5:0] mb_dev,
    input  logic       iot,
    input  logic       iop1,
    input  logic       iop2,
    input  logic       iop4,
    output logic [7:0] ac_out,
    output logic       ac_clear,
    output logic       skip,
    output logic       flag,
    output logic       active,
    output logic       framing_err
);

    localparam int              CW          = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [CW-1:0]   c_half_last = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0]   c_bit_last  = CW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    rbuf_q, rbuf_d;
    logic          flag_q, flag_d;
    logic          ferr_q, ferr_d;
    logic          sync_q, rx_q;
    logic          w_sel;

    assign w_sel = iot && (mb_dev == DEV_CODE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            rbuf_q  <= '0;
            flag_q  <= 1'b0;
            ferr_q  <= 1'b0;
            sync_q  <= 1'b1;
            rx_q    <= 1'b1;
        end else if (io_clear) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            rbuf_q  <= '0;
            flag_q  <= 1'b0;
            ferr_q  <= 1'b0;
            sync_q  <= 1'b1;
            rx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            rbuf_q  <= rbuf_d;
            flag_q  <= flag_d;
            ferr_q  <= ferr_d;
            sync_q  <= serial_in;
            rx_q    <= sync_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        rbuf_d  = rbuf_q;
        flag_d  = flag_q;
        ferr_d  = ferr_q;

        // The clear is applied first so a completing character on the same edge wins.
        if (w_sel && iop2) begin
            flag_d = 1'b0;
        end

        if (sample_tick) begin
            case (state_q)
                S_IDLE: begin
                    if (!rx_q) begin
                        state_d = S_START;
                        cnt_d   = '0;
                    end
                end
                S_START: begin
                    if (cnt_q == c_half_last) begin
                        cnt_d   = '0;
                        idx_d   = '0;
                        state_d = rx_q ? S_IDLE : S_DATA;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt_q == c_bit_last) begin
                        cnt_d          = '0;
                        shift_d[idx_q] = rx_q;
                        idx_d          = idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
                            state_d = S_STOP;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (cnt_q == c_bit_last) begin
                        cnt_d   = '0;
                        rbuf_d  = shift_q;
                        flag_d  = 1'b1;
                        ferr_d  = !rx_q;
                        state_d = rx_q ? S_IDLE : S_BREAK;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_BREAK: begin
                    if (rx_q) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign ac_out      = (w_sel && iop4) ? rbuf_q : 8'h00;
    assign ac_clear    = w_sel && iop2;
    assign skip        = w_sel && iop1 && flag_q;
    assign flag        = flag_q;
    assign framing_err = ferr_q;
    assign active      = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP);

endmodule
`default_nettype wire

// File: tb/tb_tty_receiver.sv
`default_nettype none
// ============================================================================
// tb_tty_receiver : scoreboard bench for tty_receiver (frames, glitch, break,
//                   IOT decode, flag set/clear collision, mid-frame reset)
// Revision        : 1.0
// ============================================================================
module tb_tty_receiver;

    logic       clk;
    logic       rst;
    logic       io_clear;
    logic       sample_tick;
    logic       serial_in;
    logic [5:0] mb_dev;
    logic       iot;
    logic       iop1;
    logic       iop2;
    logic       iop4;
    logic [7:0] ac_out;
    logic       ac_clear;
    logic       skip;
    logic       flag;
    logic       active;
    logic       framing_err;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic is_char;
        logic ferr;
    } exp_t;

    exp_t       cq[$];
    logic [7:0] rq[$];

    tty_receiver #(
        .OVERSAMPLE (8),
        .DEV_CODE   (6'o03)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .io_clear    (io_clear),
        .sample_tick (sample_tick),
        .serial_in   (serial_in),
        .mb_dev      (mb_dev),
        .iot         (iot),
        .iop1        (iop1),
        .iop2        (iop2),
        .iop4        (iop4),
        .ac_out      (ac_out),
        .ac_clear    (ac_clear),
        .skip        (skip),
        .flag        (flag),
        .active      (active),
        .framing_err (framing_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One-clk sample_tick every 4 clocks, changed only on falling edges.
    initial begin
        sample_tick = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            sample_tick = 1'b1;
            @(negedge clk);
            sample_tick = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got still running, expected finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!sample_tick) @(posedge clk);
        end
        @(negedge clk);
    endtask

    task automatic expect_frame(input logic is_char, input logic ferr);
        exp_t e;
        e.is_char = is_char;
        e.ferr    = ferr;
        cq.push_back(e);
    endtask

    task automatic iot_op(input logic [5:0] dev, input logic p1, input logic p2, input logic p4,
                          output logic sk, output logic acc, output logic [7:0] ao);
        @(negedge clk);
        iot = 1'b1; mb_dev = dev; iop1 = p1; iop2 = p2; iop4 = p4;
        #1;
        sk = skip; acc = ac_clear; ao = ac_out;
        @(negedge clk);
        iot = 1'b0; mb_dev = 6'o00; iop1 = 1'b0; iop2 = 1'b0; iop4 = 1'b0;
    endtask

    task automatic krs(input logic [7:0] exp);
        logic sk, acc;
        logic [7:0] ao;
        rq.push_back(exp);
        iot_op(6'o03, 1'b0, 1'b0, 1'b1, sk, acc, ao);
    endtask

    task automatic kcc();
        logic sk, acc;
        logic [7:0] ao;
        iot_op(6'o03, 1'b0, 1'b1, 1'b0, sk, acc, ao);
        chk("kcc_ac_clear", acc, 1);
        #1 chk("kcc_flag_cleared", flag, 0);
    endtask

    // Full frame; with collide set, KCC is pulsed on the tick that samples the stop bit.
    task automatic send(input logic [7:0] d, input logic stop_bit, input logic collide);
        wait_ticks(1);
        serial_in = 1'b0;
        wait_ticks(1);
        #1 chk("active_after_start", active, 1);
        wait_ticks(7);
        for (int i = 0; i < 8; i++) begin
            serial_in = d[i];
            wait_ticks(8);
        end
        serial_in = stop_bit;
        if (collide) begin
            wait_ticks(4);
            do begin
                @(negedge clk);
                #1;
            end while (!sample_tick);
            iot = 1'b1; mb_dev = 6'o03; iop2 = 1'b1;
            #1 chk("collide_ac_clear", ac_clear, 1);
            @(negedge clk);
            iot = 1'b0; mb_dev = 6'o00; iop2 = 1'b0;
            wait_ticks(3);
        end else begin
            wait_ticks(8);
        end
    endtask

    // Monitor: frame completions are seen as active falling; reads as gated KRS pulses.
    initial begin
        exp_t e;
        logic act_prev;
        act_prev = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst && act_prev && !active) begin
                total++;
                if (cq.size() == 0) begin
                    bad++;
                    $display("FAIL frame_end: got unexpected end of reception, expected none");
                end else begin
                    total--;
                    e = cq.pop_front();
                    if (e.is_char) begin
                        chk("frame_flag", flag, 1);
                        chk("frame_ferr", framing_err, e.ferr);
                    end else begin
                        chk("glitch_flag", flag, 0);
                    end
                end
            end
            if (iot && iop4 && (mb_dev == 6'o03)) begin
                if (rq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL krs_read: got unexpected read %0h, expected none", ac_out);
                end else begin
                    chk("krs_ac_out", ac_out, rq.pop_front());
                end
            end
            act_prev = active;
        end
    end

    initial begin
        logic sk, acc;
        logic [7:0] ao;
        logic [7:0] partial;

        rst = 1'b1; io_clear = 1'b0; serial_in = 1'b1;
        mb_dev = 6'o00; iot = 1'b0; iop1 = 1'b0; iop2 = 1'b0; iop4 = 1'b0;
        #23;
        chk("rst_flag", flag, 0);
        chk("rst_active", active, 0);
        chk("rst_ferr", framing_err, 0);
        chk("rst_skip", skip, 0);
        chk("rst_ac_clear", ac_clear, 0);
        chk("rst_ac_out", ac_out, 0);
        @(negedge clk);
        rst = 1'b0;
        wait_ticks(4);

        // Clean character
        expect_frame(1'b1, 1'b0);
        send(8'h41, 1'b1, 1'b0);
        #1 chk("c41_active", active, 0);
        chk("c41_flag", flag, 1);
        krs(8'h41);

        // io_clear behaves like reset
        @(negedge clk); io_clear = 1'b1;
        @(negedge clk); io_clear = 1'b0;
        #1 chk("ioclr_flag", flag, 0);
        krs(8'h00);

        // Start-bit glitch: 3 low ticks
        expect_frame(1'b0, 1'b0);
        wait_ticks(1);
        serial_in = 1'b0;
        wait_ticks(1);
        #1 chk("glitch_active_t0", active, 1);
        wait_ticks(2);
        serial_in = 1'b1;
        wait_ticks(1);
        #1 chk("glitch_active_t3", active, 1);
        wait_ticks(1);
        #1 chk("glitch_active_t4", active, 0);
        wait_ticks(8);
        chk("glitch_flag_after", flag, 0);

        // Low stop bit followed by held-low line
        expect_frame(1'b1, 1'b1);
        send(8'h00, 1'b0, 1'b0);
        wait_ticks(40);
        #1 chk("break_active", active, 0);
        chk("break_ferr", framing_err, 1);
        serial_in = 1'b1;
        wait_ticks(8);
        krs(8'h00);
        kcc();
        expect_frame(1'b1, 1'b0);
        send(8'h7F, 1'b1, 1'b0);
        #1 chk("c7f_ferr", framing_err, 0);
        krs(8'h7F);
        kcc();

        // IOT sequence on 0xC5
        expect_frame(1'b1, 1'b0);
        send(8'hC5, 1'b1, 1'b0);
        #1 chk("idle_ac_out", ac_out, 0);
        iot_op(6'o03, 1'b1, 1'b0, 1'b0, sk, acc, ao);
        chk("ksf_skip_set", sk, 1);
        iot_op(6'o04, 1'b1, 1'b1, 1'b1, sk, acc, ao);
        chk("wrongdev_skip", sk, 0);
        chk("wrongdev_ac_clear", acc, 0);
        chk("wrongdev_ac_out", ao, 0);
        #1 chk("wrongdev_flag_kept", flag, 1);
        kcc();
        iot_op(6'o03, 1'b1, 1'b0, 1'b0, sk, acc, ao);
        chk("ksf_skip_clear", sk, 0);
        krs(8'hC5);

        // Flag set and clear on the same edge
        expect_frame(1'b1, 1'b0);
        send(8'h33, 1'b1, 1'b1);
        #1 chk("collide_flag", flag, 1);
        krs(8'h33);

        // Asynchronous reset in the middle of data bit 4
        partial = 8'hAA;
        wait_ticks(1);
        serial_in = 1'b0;
        wait_ticks(8);
        for (int i = 0; i < 4; i++) begin
            serial_in = partial[i];
            wait_ticks(8);
        end
        serial_in = partial[4];
        wait_ticks(4);
        #2 rst = 1'b1;
        #1 chk("midrst_active", active, 0);
        chk("midrst_flag", flag, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        serial_in = 1'b1;
        krs(8'h00);
        wait_ticks(16);
        expect_frame(1'b1, 1'b0);
        send(8'h55, 1'b1, 1'b0);
        krs(8'h55);

        repeat (8) @(negedge clk);
        chk("frames_pending", cq.size(), 0);
        chk("reads_pending", rq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
